red_serial_tx: RTL and testbench

RED_SERIAL_TX -- requirements
Module: red_serial_tx

---
 rtl/red_serial_tx.sv | 144 ++++++++++++++
 tb/tb_red_serial_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/red_serial_tx.sv
// Triple-repetition UART-style serial transmitter: every logical bit goes out as three identical chips.
// Define RED_SERIAL_TX_PARITY_EN to add an even-parity bit after the payload MSB.
module red_serial_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        stateDbg
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef RED_SERIAL_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Handshake: a payload moves when valid_i and ready_o are both high at a rising clk edge.
    state_t            state;
    logic [DATA_W-1:0] shiftReg;
    logic [CW-1:0]     cycleCnt;
    logic [1:0]        chipCnt;
    logic [BW-1:0]     bitCnt;
`ifdef RED_SERIAL_TX_PARITY_EN
    logic              parityBit;
`endif

    logic          handshake;
    logic          chipEnd;
    logic          bitEnd;
    logic [CW-1:0] nextCycle;
    logic [1:0]    nextChip;
    logic          doneNext;

    assign stateDbg = state;

    // doneNext looks one cycle ahead so done_o can be a plain register.
    always_comb begin
        handshake = valid_i && ready_o;
        chipEnd   = (cycleCnt == CYC_LAST);
        bitEnd    = chipEnd && (chipCnt == 2'd2);
        nextCycle = chipEnd ? '0 : cycleCnt + CW'(1);
        nextChip  = chipCnt;
        if (chipEnd) begin
            nextChip = (chipCnt == 2'd2) ? 2'd0 : chipCnt + 2'd1;
        end
        doneNext  = (state == STOP) && !bitEnd && (nextChip == 2'd2) && (nextCycle == CYC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_o      <= 1'b1;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            shiftReg  <= '0;
            cycleCnt  <= '0;
            chipCnt   <= 2'd0;
            bitCnt    <= '0;
`ifdef RED_SERIAL_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else if (state == IDLE) begin
            ready_o <= 1'b1;
            tx_o    <= 1'b1;
            done_o  <= 1'b0;
            if (handshake) begin
                state     <= START;
                ready_o   <= 1'b0;
                busy_o    <= 1'b1;
                tx_o      <= 1'b0;
                shiftReg  <= data_i;
                cycleCnt  <= '0;
                chipCnt   <= 2'd0;
`ifdef RED_SERIAL_TX_PARITY_EN
                parityBit <= ^data_i;
`endif
            end
        end else begin
            cycleCnt <= nextCycle;
            chipCnt  <= nextChip;
            done_o   <= doneNext;
            if (bitEnd) begin
                case (state)
                    START: begin
                        state    <= DATA;
                        bitCnt   <= '0;
                        tx_o     <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                    end
                    DATA: begin
                        if (bitCnt == BIT_LAST) begin
`ifdef RED_SERIAL_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= parityBit;
`else
                            state <= STOP;
                            tx_o  <= 1'b1;
`endif
                        end else begin
                            bitCnt   <= bitCnt + BW'(1);
                            tx_o     <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                        end
                    end
`ifdef RED_SERIAL_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end
`endif
                    STOP: begin
                        // ready_o rises together with the return to IDLE, one cycle after done_o.
                        state   <= IDLE;
                        tx_o    <= 1'b1;
                        busy_o  <= 1'b0;
                        ready_o <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_serial_tx.sv
// Directed bench for red_serial_tx: DATA_W=8 at BIT_CYCLES=2 and BIT_CYCLES=1.
// Expectations follow RED_SERIAL_TX_PARITY_EN when it is defined for the whole build.
module tb_red_serial_tx;

    localparam int DW = 8;
    localparam int BC = 2;
`ifdef RED_SERIAL_TX_PARITY_EN
    localparam int PAR     = 1;
    localparam int LEN_A5  = 66;
    localparam int LEN_MIN = 33;
`else
    localparam int PAR     = 0;
    localparam int LEN_A5  = 60;
    localparam int LEN_MIN = 30;
`endif
    localparam int NFRAME = 3 * (DW + 2 + PAR) * BC;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready, tx, busy, done;
    logic [2:0]    stateDbg;
    logic [DW-1:0] minData;
    logic          minValid;
    logic          minReady, minTx, minBusy, minDone;
    logic [2:0]    minStateDbg;

    logic useMin;
    logic curReady, curTx, curBusy, curDone;

    int checks = 0;
    int errors = 0;

    red_serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid),
        .ready_o(ready), .tx_o(tx), .busy_o(busy), .done_o(done), .stateDbg(stateDbg)
    );

    red_serial_tx #(.DATA_W(DW), .BIT_CYCLES(1)) dutMin (
        .clk(clk), .rst_n(rst_n), .data_i(minData), .valid_i(minValid),
        .ready_o(minReady), .tx_o(minTx), .busy_o(minBusy), .done_o(minDone), .stateDbg(minStateDbg)
    );

    assign curReady = useMin ? minReady : ready;
    assign curTx    = useMin ? minTx    : tx;
    assign curBusy  = useMin ? minBusy  : busy;
    assign curDone  = useMin ? minDone  : done;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference chip stream, first chip in the most significant position.
    function automatic logic [35:0] expChips(input logic [7:0] d);
        logic [35:0] v;
        v = '0;
        v = {v[32:0], 3'b000};
        for (int i = 0; i < 8; i++) v = {v[32:0], {3{d[i]}}};
`ifdef RED_SERIAL_TX_PARITY_EN
        v = {v[32:0], {3{^d}}};
`endif
        v = {v[32:0], 3'b111};
        return v;
    endfunction

    // driver tasks
    task automatic driveIn(input logic v, input logic [7:0] d);
        if (useMin) begin
            minValid = v;
            minData  = d;
        end else begin
            valid = v;
            data  = d;
        end
    endtask

    task automatic startFrame(input string tag, input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!curReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkVal({tag, "_ready"}, 64'(curReady), 64'd1);
        driveIn(1'b1, d);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] d, input int n, input int bc,
                              input logic [7:0] newData, input bit keepValid, input bit poke,
                              output logic [35:0] chips);
        int   doneAt, doneCnt, busyLow, glitch;
        logic lastChip;
        chips = '0; doneAt = 0; doneCnt = 0; busyLow = 0; glitch = 0; lastChip = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) driveIn(keepValid, newData);
            if (poke && i >= 10 && i <= 20) begin
                valid = (i % 2 == 0);
                data  = 8'(i * 7);
            end
            if (poke && i == 21) valid = 1'b0;
            if ((i - 1) % bc == 0) begin
                chips    = {chips[34:0], curTx};
                lastChip = curTx;
            end else if (curTx !== lastChip) begin
                glitch++;
            end
            if (curDone === 1'b1) begin
                doneCnt++;
                if (doneAt == 0) doneAt = i;
            end
            if (curBusy !== 1'b1) busyLow++;
        end
        checkVal({tag, "_chips"}, 64'(chips), 64'(expChips(d)));
        checkVal({tag, "_done_at"}, 64'(doneAt), 64'(n));
        checkVal({tag, "_done_cnt"}, 64'(doneCnt), 64'd1);
        checkVal({tag, "_busy_glitch"}, {32'(busyLow), 32'(glitch)}, 64'd0);
    endtask

    // main sequence
    initial begin
        logic [35:0] chips;
        int          cnt;
        rst_n = 1'b0; valid = 1'b0; data = '0; minValid = 1'b0; minData = '0; useMin = 1'b0;

        repeat (3) @(negedge clk);
        checkVal("reset_outs", {ready, tx, busy, done}, 4'b0100);
        checkVal("reset_state", 64'(stateDbg), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("ready_after_release", {ready, minReady}, 2'b11);

        // basic frame, data changed right after the handshake
        startFrame("a5", 8'hA5);
        checkFrame("a5", 8'hA5, LEN_A5, BC, 8'h5A, 1'b0, 1'b0, chips);
`ifdef RED_SERIAL_TX_PARITY_EN
        checkVal("a5_hand", 64'(chips), 64'(36'b000_000111000111000000111000111000111));
        checkVal("a5_parity", 64'(chips[5:3]), 64'(3'b000));
`else
        checkVal("a5_hand", 64'(chips), 64'(36'b000000_000111000111000000111000111111));
`endif
        @(negedge clk);
        checkVal("a5_idle", {ready, tx, busy, done}, 4'b1100);

        startFrame("p01", 8'h01);
        checkFrame("p01", 8'h01, NFRAME, BC, 8'h00, 1'b0, 1'b0, chips);
`ifdef RED_SERIAL_TX_PARITY_EN
        checkVal("p01_parity", 64'(chips[5:3]), 64'(3'b111));
`endif

        // back-to-back with valid held high
        startFrame("b2b1", 8'h00);
        checkFrame("b2b1", 8'h00, NFRAME, BC, 8'hFF, 1'b1, 1'b0, chips);
        @(negedge clk);
        checkVal("b2b_gap", {ready, tx, busy, done}, 4'b1100);
        checkFrame("b2b2", 8'hFF, NFRAME, BC, 8'hFF, 1'b0, 1'b0, chips);

        // valid pulses and data toggles while busy
        startFrame("busy", 8'hC3);
        checkFrame("busy", 8'hC3, NFRAME, BC, 8'hC3, 1'b0, 1'b1, chips);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        checkVal("busy_no_second", 64'(cnt), 64'd0);

        // reset in cycle 20 of a frame
        startFrame("rst", 8'h3C);
        @(negedge clk);
        valid = 1'b0;
        repeat (19) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkVal("rst_async", {ready, tx, busy, done}, 4'b0100);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1) cnt++;
        end
        checkVal("rst_no_done", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("rst_ready", {ready, tx, busy}, 3'b110);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        checkVal("rst_no_resume", 64'(cnt), 64'd0);
        startFrame("rst_again", 8'h3C);
        checkFrame("rst_again", 8'h3C, NFRAME, BC, 8'h00, 1'b0, 1'b0, chips);

        // one clk cycle per chip
        useMin = 1'b1;
        startFrame("min", 8'h80);
        checkFrame("min", 8'h80, LEN_MIN, 1, 8'h80, 1'b0, 1'b0, chips);
        checkVal("min_last_data", 64'(chips[3 + 3 * PAR +: 3]), 64'(3'b111));
        @(negedge clk);
        checkVal("min_idle", {minReady, minTx, minBusy, minDone}, 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
